ex_muldiv_stage: RTL

//  Parametrised execute stage: N-source operand forwarding, single-cycle ALU, iterative

---
 rtl/ex_muldiv_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - execute stage: operand forwarding, ALU, iterative RV32M mul/div
// Define EX_DIV_EN to build the divider; otherwise DIV-class ops return 0 at ALU timing.
module ex_muldiv_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  localparam int FSW    = $clog2(NUM_FWD + 1),
  localparam int SHW    = $clog2(XLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    flush,
  input  logic [1:0]              op_class,
  input  logic [2:0]              aluop,
  input  logic [1:0]              mdop,
  input  logic [XLEN-1:0]         a_local,
  input  logic [XLEN-1:0]         b_local,
  input  logic [FSW-1:0]          a_fwd_sel,
  input  logic [FSW-1:0]          b_fwd_sel,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]         result,
  output logic                    result_valid,
  output logic                    stall
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [FSW-1:0] FMAX = FSW'(NUM_FWD);

  state_t           state;
  logic [SHW-1:0]   count;
  logic [XLEN-1:0]  acc_hi, acc_lo, opnd, res_reg;
  logic [1:0]       mdop_r;
  logic             sa_r, sb_r;
`ifdef EX_DIV_EN
  logic             is_div_r, div0_r;
`endif

  // Out-of-range selects fall back to the local operand.
  function automatic logic [XLEN-1:0] pick(input logic [FSW-1:0] sel,
                                           input logic [XLEN-1:0] loc,
                                           input logic [NUM_FWD*XLEN-1:0] fwd);
    logic [XLEN-1:0] v;
    v = loc;
    for (int k = 1; k <= NUM_FWD; k++)
      if (sel == FSW'(k)) v = fwd[(k-1)*XLEN +: XLEN];
    return v;
  endfunction

  logic [XLEN-1:0] a_op, b_op, alu_y, a_mag, b_mag;
  logic            is_mul, is_div_in, is_alu, launch, sgn_a, sgn_b, sa_in, sb_in;

  assign a_op   = pick(a_fwd_sel, a_local, fwd_data);
  assign b_op   = pick(b_fwd_sel, b_local, fwd_data);
  assign is_mul = (op_class == 2'd1);
`ifdef EX_DIV_EN
  assign is_div_in = (op_class == 2'd2);
`else
  assign is_div_in = 1'b0;
`endif
  assign is_alu = (op_class == 2'd0) || (op_class == 2'd3);
  assign launch = (state == S_IDLE) && in_valid && !flush && !rst && (is_mul || is_div_in);

  always_comb begin
    alu_y = '0;
    case (aluop)
      3'd0: alu_y = a_op + b_op;
      3'd1: alu_y = a_op << b_op[SHW-1:0];
      3'd2: alu_y = $signed(a_op) >>> b_op[SHW-1:0];
      3'd3: alu_y = a_op - b_op;
      3'd4: alu_y = a_op ^ b_op;
      3'd5: alu_y = a_op >> b_op[SHW-1:0];
      3'd6: alu_y = a_op | b_op;
      default: alu_y = a_op & b_op;
    endcase
  end

  // Iteration runs on magnitudes; signs are kept aside for the final fixup.
  always_comb begin
    if (is_mul) begin
      sgn_a = (mdop == 2'd1) || (mdop == 2'd2);
      sgn_b = (mdop == 2'd1);
    end else begin
      sgn_a = ~mdop[0];
      sgn_b = ~mdop[0];
    end
    sa_in = sgn_a & a_op[XLEN-1];
    sb_in = sgn_b & b_op[XLEN-1];
    a_mag = sa_in ? -a_op : a_op;
    b_mag = sb_in ? -b_op : b_op;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   hi_nx, lo_nx, mul_res, fin;
  logic [2*XLEN-1:0] prod, prod_s;
`ifdef EX_DIV_EN
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   quo, rem;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    hi_nx   = mul_sum[XLEN:1];
    lo_nx   = {mul_sum[0], acc_lo[XLEN-1:1]};
`ifdef EX_DIV_EN
    div_sh   = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (is_div_r) begin
      if (!div_diff[XLEN]) begin
        hi_nx = div_diff[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = div_sh[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
`endif
    prod    = {hi_nx, lo_nx};
    prod_s  = (sa_r ^ sb_r) ? -prod : prod;
    mul_res = (mdop_r == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef EX_DIV_EN
    quo = div0_r ? '1 : ((sa_r ^ sb_r) ? -lo_nx : lo_nx);
    rem = sa_r ? -hi_nx : hi_nx;
    fin = is_div_r ? (mdop_r[1] ? rem : quo) : mul_res;
`else
    fin = mul_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      res_reg <= '0;
      mdop_r  <= '0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
`ifdef EX_DIV_EN
      is_div_r <= 1'b0;
      div0_r   <= 1'b0;
`endif
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (launch) begin
          state  <= S_RUN;
          count  <= SHW'(XLEN - 1);
          acc_hi <= '0;
          acc_lo <= is_div_in ? a_mag : b_mag;
          opnd   <= is_div_in ? b_mag : a_mag;
          mdop_r <= mdop;
          sa_r   <= sa_in;
          sb_r   <= sb_in;
`ifdef EX_DIV_EN
          is_div_r <= is_div_in;
          div0_r   <= (b_op == '0);
`endif
        end
        S_RUN: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          count  <= count - 1'b1;
          if (count == '0) begin
            res_reg <= fin;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    result       = '0;
    result_valid = 1'b0;
    stall        = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          stall        = launch;
          result       = is_alu ? alu_y : '0;
          result_valid = in_valid && !flush && !(is_mul || is_div_in);
        end
        S_RUN:  stall = 1'b1;
        default: begin
          result       = res_reg;
          result_valid = !flush;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    in_valid |-> (a_fwd_sel <= FMAX && b_fwd_sel <= FMAX));

endmodule
